// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Package : div_pkg
// Shared FSM encoding, sign helper and RISC-V divide-by-zero results.
// Rev     : 1.0
// ============================================================================
package div_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } div_state_e;

  // Helpers work on a 64-bit container; callers cast down to XLEN, and the low
  // bits of a two's-complement negate are independent of the container width.
  localparam int NEG_W = 64;

  localparam logic [NEG_W-1:0] DIV0_Q = '1;

  function automatic logic [NEG_W-1:0] cond_neg(input logic [NEG_W-1:0] v,
                                                 input logic             neg);
    return neg ? (~v + NEG_W'(1)) : v;
  endfunction

  // Divide by zero returns the dividend untouched as the remainder.
  function automatic logic [NEG_W-1:0] div0_r(input logic [NEG_W-1:0] dividend);
    return dividend;
  endfunction

endpackage
`default_nettype wire

// File: rtl/div_restoring_step.sv
`default_nettype none
// ============================================================================
// Module : div_restoring_step
// One combinational restoring-division iteration (shift, trial subtract).
// Rev    : 1.0
// ============================================================================
module div_restoring_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] dvs,
  output logic [XLEN-1:0] rem_nxt,
  output logic [XLEN-1:0] quo_nxt
);

  logic [XLEN:0] w_trial;
  logic          w_restore;

  // A set MSB means the partial remainder was smaller than the divisor.
  assign w_trial   = {rem, quo[XLEN-1]} - {1'b0, dvs};
  assign w_restore = w_trial[XLEN];

  assign quo_nxt = {quo[XLEN-2:0], ~w_restore};
  assign rem_nxt = w_restore ? {rem[XLEN-2:0], quo[XLEN-1]} : w_trial[XLEN-1:0];

endmodule
`default_nettype wire

// File: rtl/div_restoring_seq.sv
`default_nettype none
// ============================================================================
// Module : div_restoring_seq
// Sequential restoring divider for DIV/DIVU/REM/REMU, one bit per cycle.
// Rev    : 1.0
// ============================================================================
module div_restoring_seq
  import div_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN + 1)
) (
  input  logic            clk,
  input  logic            rstlow,
  input  logic            start,
  input  logic            kill,
  input  logic            op_signed,
  input  logic [XLEN-1:0] a_in,
  input  logic [XLEN-1:0] b_in,
  output logic            busy,
  output logic            done,
  output logic            div_zero,
  output logic [XLEN-1:0] q_out,
  output logic [XLEN-1:0] r_out
);

  div_state_e       r_state;
  div_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [XLEN-1:0]  r_rem;
  logic [XLEN-1:0]  r_quo;
  logic [XLEN-1:0]  r_dvs;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_busy;

  logic             w_accept;
  logic             w_div0;
  logic             w_finish;
  logic             w_abort;
  logic             w_step_en;
  logic             w_last_step;
  logic             w_b_zero;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [XLEN-1:0]  w_a_mag;
  logic [XLEN-1:0]  w_b_mag;
  logic [XLEN-1:0]  w_rem_nxt;
  logic [XLEN-1:0]  w_quo_nxt;

  assign w_b_zero    = (b_in == '0);
  assign w_a_neg     = op_signed & a_in[XLEN-1];
  assign w_b_neg     = op_signed & b_in[XLEN-1];
  assign w_a_mag     = XLEN'(cond_neg(64'(a_in), w_a_neg));
  assign w_b_mag     = XLEN'(cond_neg(64'(b_in), w_b_neg));
  assign w_last_step = (r_cnt == CNT_W'(XLEN - 1));
  assign w_step_en   = (r_state == S_CALC) && !kill;
  assign busy        = r_busy;

  div_restoring_step #(
    .XLEN (XLEN)
  ) u_step (
    .rem     (r_rem),
    .quo     (r_quo),
    .dvs     (r_dvs),
    .rem_nxt (w_rem_nxt),
    .quo_nxt (w_quo_nxt)
  );

  always_ff @(posedge clk or negedge rstlow) begin
    if (!rstlow) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // kill wins over start in IDLE and aborts CALC/FIX without a done pulse.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_div0      = 1'b0;
    w_finish    = 1'b0;
    w_abort     = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !kill) begin
          if (w_b_zero) begin
            w_state_nxt = S_DONE;
            w_div0      = 1'b1;
          end else begin
            w_state_nxt = S_CALC;
            w_accept    = 1'b1;
          end
        end
      end
      S_CALC: begin
        if (kill) begin
          w_state_nxt = S_IDLE;
          w_abort     = 1'b1;
        end else if (w_last_step) begin
          w_state_nxt = S_FIX;
        end
      end
      S_FIX: begin
        if (kill) begin
          w_state_nxt = S_IDLE;
          w_abort     = 1'b1;
        end else begin
          w_state_nxt = S_DONE;
          w_finish    = 1'b1;
        end
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstlow) begin
    if (!rstlow) begin
      r_cnt    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvs    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_busy   <= 1'b0;
      div_zero <= 1'b0;
      q_out    <= '0;
      r_out    <= '0;
    end else begin
      if (w_accept) begin
        r_quo   <= w_a_mag;
        r_rem   <= '0;
        r_dvs   <= w_b_mag;
        r_neg_q <= w_a_neg ^ w_b_neg;
        r_neg_r <= w_a_neg;
        r_cnt   <= '0;
        r_busy  <= 1'b1;
      end
      if (w_step_en) begin
        r_quo <= w_quo_nxt;
        r_rem <= w_rem_nxt;
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_div0) begin
        q_out    <= XLEN'(DIV0_Q);
        r_out    <= XLEN'(div0_r(64'(a_in)));
        div_zero <= 1'b1;
      end
      // The -2^(XLEN-1) / -1 overflow case needs no special handling here.
      if (w_finish) begin
        q_out    <= XLEN'(cond_neg(64'(r_quo), r_neg_q));
        r_out    <= XLEN'(cond_neg(64'(r_rem), r_neg_r));
        div_zero <= 1'b0;
        r_busy   <= 1'b0;
      end
      if (w_abort) begin
        r_busy <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_div_restoring_seq.sv
`default_nettype none
// ============================================================================
// Module : tb_div_restoring_seq
// Self-checking bench for div_restoring_seq at XLEN=32 and XLEN=8.
// Rev    : 1.0
// ============================================================================
module tb_div_restoring_seq;

  logic        clk = 1'b0;
  logic        rstlow;
  logic        start32, kill32, sgn32;
  logic [31:0] a32, b32;
  logic        busy32, done32, dz32;
  logic [31:0] q32, r32;
  logic        start8, kill8, sgn8;
  logic [7:0]  a8, b8;
  logic        busy8, done8, dz8;
  logic [7:0]  q8, r8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div_restoring_seq #(.XLEN(32)) dut32 (
    .clk(clk), .rstlow(rstlow), .start(start32), .kill(kill32), .op_signed(sgn32),
    .a_in(a32), .b_in(b32), .busy(busy32), .done(done32), .div_zero(dz32),
    .q_out(q32), .r_out(r32)
  );

  div_restoring_seq #(.XLEN(8)) dut8 (
    .clk(clk), .rstlow(rstlow), .start(start8), .kill(kill8), .op_signed(sgn8),
    .a_in(a8), .b_in(b8), .busy(busy8), .done(done8), .div_zero(dz8),
    .q_out(q8), .r_out(r8)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sgn;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer division with RISC-V divide-by-zero rule.
  function automatic void model(input int w, input logic [31:0] a, input logic [31:0] b,
                                input logic sgn, output logic [31:0] q,
                                output logic [31:0] r, output logic dz);
    longint      sa, sb, sq, sr;
    logic [31:0] mask, am, bm;
    mask = (w == 8) ? 32'h0000_00FF : 32'hFFFF_FFFF;
    am   = a & mask;
    bm   = b & mask;
    if (bm == 32'd0) begin
      q  = mask;
      r  = am;
      dz = 1'b1;
      return;
    end
    dz = 1'b0;
    if (sgn) begin
      if (w == 8) begin
        sa = longint'($signed(am[7:0]));
        sb = longint'($signed(bm[7:0]));
      end else begin
        sa = longint'($signed(am));
        sb = longint'($signed(bm));
      end
      sq = sa / sb;
      sr = sa % sb;
      q  = sq[31:0] & mask;
      r  = sr[31:0] & mask;
    end else begin
      q = am / bm;
      r = am % bm;
    end
  endfunction

  // Launches one op; returns results sampled in the done cycle, the number of
  // negedges from the start edge to done, and the count of busy-high samples.
  task automatic run_op(input bit w8, input logic [31:0] a, input logic [31:0] b,
                        input logic sgn, output logic [31:0] q, output logic [31:0] r,
                        output logic dz, output int lat, output int bcnt);
    bit seen;
    seen = 1'b0;
    lat  = 0;
    bcnt = 0;
    q    = '0;
    r    = '0;
    dz   = 1'b0;
    if (w8) begin a8 = a[7:0]; b8 = b[7:0]; sgn8 = sgn; start8 = 1'b1; end
    else    begin a32 = a;     b32 = b;     sgn32 = sgn; start32 = 1'b1; end
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      start8  = 1'b0;
      start32 = 1'b0;
      a32  = $urandom; b32 = $urandom; sgn32 = 1'($urandom);
      a8   = 8'($urandom); b8 = 8'($urandom); sgn8 = 1'($urandom);
      lat++;
      if (w8 ? busy8 : busy32) bcnt++;
      if (w8 ? done8 : done32) begin
        seen = 1'b1;
        q  = w8 ? {24'd0, q8} : q32;
        r  = w8 ? {24'd0, r8} : r32;
        dz = w8 ? dz8 : dz32;
      end
    end
    check("done_within_budget", 64'(seen), 64'd1);
    @(negedge clk);
    check("done_single_pulse", 64'(w8 ? done8 : done32), 64'd0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs [10];
    logic [31:0] q, r, eq, er;
    logic        dz, edz;
    int          lat, bcnt, dcnt, bsum;
    bit          seen;
    logic [7:0]  a8_list [7];

    vecs[0] = '{32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1'b0};
    vecs[1] = '{32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0};
    vecs[2] = '{32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1,          1'b0};
    vecs[3] = '{32'h1234_5678,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'h1234_5678,  1'b1};
    vecs[4] = '{32'h1234_5678,  32'd0,          1'b0, 32'hFFFF_FFFF,  32'h1234_5678,  1'b1};
    vecs[5] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0,          1'b0};
    vecs[6] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 32'd0,          32'h8000_0000,  1'b0};
    vecs[7] = '{32'd5,          32'd9,          1'b0, 32'd0,          32'd5,          1'b0};
    vecs[8] = '{32'hFFFF_FFFB,  32'd9,          1'b1, 32'd0,          32'hFFFF_FFFB,  1'b0};
    vecs[9] = '{32'd9,          32'hFFFF_FFFB,  1'b1, 32'hFFFF_FFFF,  32'd4,          1'b0};
    a8_list = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF, 8'h55, 8'hAA};

    rstlow = 1'b0;
    start32 = 1'b0; kill32 = 1'b0; sgn32 = 1'b0; a32 = '0; b32 = '0;
    start8  = 1'b0; kill8  = 1'b0; sgn8  = 1'b0; a8  = '0; b8  = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy32), 64'd0);
    check("rst_done", 64'(done32), 64'd0);
    check("rst_dz",   64'(dz32),   64'd0);
    check("rst_q",    64'(q32),    64'd0);
    check("rst_r",    64'(r32),    64'd0);
    check("rst_q8",   64'({dz8, busy8, done8, q8, r8}), 64'd0);
    rstlow = 1'b1;
    @(negedge clk);

    // Directed table at XLEN=32.
    for (int i = 0; i < 10; i++) begin
      run_op(1'b0, vecs[i].a, vecs[i].b, vecs[i].sgn, q, r, dz, lat, bcnt);
      check($sformatf("vec%0d_q", i),    64'(q),    64'(vecs[i].q));
      check($sformatf("vec%0d_r", i),    64'(r),    64'(vecs[i].r));
      check($sformatf("vec%0d_dz", i),   64'(dz),   64'(vecs[i].dz));
      check($sformatf("vec%0d_lat", i),  64'(lat),  vecs[i].dz ? 64'd1 : 64'd34);
      check($sformatf("vec%0d_busy", i), 64'(bcnt), vecs[i].dz ? 64'd0 : 64'd33);
    end

    // Outputs hold after completion.
    repeat (5) @(negedge clk);
    check("hold_q", 64'(q32), 64'hFFFF_FFFF);
    check("hold_r", 64'(r32), 64'd4);

    // Randomized XLEN=32 against the model.
    for (int i = 0; i < 150; i++) begin
      logic [31:0] ra, rb;
      logic        rs;
      int          sel;
      ra  = $urandom;
      sel = $urandom_range(0, 9);
      rb  = (sel == 0) ? 32'd0 : (sel < 4) ? 32'($urandom_range(1, 255)) :
            (sel == 4) ? 32'hFFFF_FFFF : 32'($urandom);
      if (sel == 5) ra = 32'h8000_0000;
      rs  = 1'($urandom);
      model(32, ra, rb, rs, eq, er, edz);
      run_op(1'b0, ra, rb, rs, q, r, dz, lat, bcnt);
      check("rnd32_q",   64'(q),   64'(eq));
      check("rnd32_r",   64'(r),   64'(er));
      check("rnd32_dz",  64'(dz),  64'(edz));
      check("rnd32_lat", 64'(lat), edz ? 64'd1 : 64'd34);
    end

    // Start pulse at step 10 is ignored.
    seen = 1'b0; lat = 0;
    a32 = 32'd100; b32 = 32'd7; sgn32 = 1'b0; start32 = 1'b1;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      lat++;
      start32 = (lat == 10);
      a32 = 32'd1; b32 = 32'd1;
      if (done32) seen = 1'b1;
    end
    start32 = 1'b0;
    check("restart_seen", 64'(seen), 64'd1);
    check("restart_lat",  64'(lat),  64'd34);
    check("restart_q",    64'(q32),  64'd14);
    check("restart_r",    64'(r32),  64'd2);
    @(negedge clk);

    // Divide by zero, then a killed op must leave those results in place.
    run_op(1'b0, 32'h1234_5678, 32'd0, 1'b0, q, r, dz, lat, bcnt);
    a32 = 32'h1000; b32 = 32'd3; sgn32 = 1'b0; start32 = 1'b1;
    lat = 0; dcnt = 0; bsum = 0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      lat++;
      start32 = 1'b0;
      kill32  = (lat == 5);
      if (lat == 6) check("kill_busy_drop", 64'(busy32), 64'd0);
      if (lat > 6 && busy32) bsum++;
      if (done32) dcnt++;
    end
    kill32 = 1'b0;
    check("kill_no_done", 64'(dcnt), 64'd0);
    check("kill_idle",    64'(bsum), 64'd0);
    check("kill_q",  64'(q32),  64'hFFFF_FFFF);
    check("kill_r",  64'(r32),  64'h1234_5678);
    check("kill_dz", 64'(dz32), 64'd1);

    // kill and start together in IDLE: start dropped.
    a32 = 32'd50; b32 = 32'd5; start32 = 1'b1; kill32 = 1'b1;
    dcnt = 0; bsum = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start32 = 1'b0; kill32 = 1'b0;
      if (busy32) bsum++;
      if (done32) dcnt++;
    end
    check("killstart_busy", 64'(bsum), 64'd0);
    check("killstart_done", 64'(dcnt), 64'd0);
    check("killstart_q",    64'(q32),  64'hFFFF_FFFF);

    // Asynchronous reset at step 20.
    a32 = 32'd100; b32 = 32'd7; sgn32 = 1'b0; start32 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      start32 = 1'b0;
    end
    rstlow = 1'b0;
    #1;
    check("midrst_outs", 64'({busy32, done32, dz32}), 64'd0);
    check("midrst_q",    64'(q32), 64'd0);
    check("midrst_r",    64'(r32), 64'd0);
    @(negedge clk);
    rstlow = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done32 || busy32) dcnt++;
    end
    check("midrst_quiet", 64'(dcnt), 64'd0);

    // XLEN=8: every divisor against corner dividends, both modes.
    for (int s = 0; s < 2; s++) begin
      for (int ai = 0; ai < 7; ai++) begin
        for (int bi = 0; bi < 256; bi++) begin
          model(8, 32'(a8_list[ai]), 32'(bi), 1'(s), eq, er, edz);
          run_op(1'b1, 32'(a8_list[ai]), 32'(bi), 1'(s), q, r, dz, lat, bcnt);
          check($sformatf("x8_a%0h_b%0h_s%0d", a8_list[ai], bi, s),
                64'({dz, q[7:0], r[7:0]}), 64'({edz, eq[7:0], er[7:0]}));
          check("x8_lat", 64'(lat), edz ? 64'd1 : 64'd10);
        end
      end
    end

    // XLEN=8 random pairs.
    for (int i = 0; i < 300; i++) begin
      logic [31:0] ra, rb;
      logic        rs;
      ra = 32'($urandom_range(0, 255));
      rb = 32'($urandom_range(0, 255));
      rs = 1'($urandom);
      model(8, ra, rb, rs, eq, er, edz);
      run_op(1'b1, ra, rb, rs, q, r, dz, lat, bcnt);
      check("rnd8_res", 64'({dz, q[7:0], r[7:0]}), 64'({edz, eq[7:0], er[7:0]}));
      check("rnd8_busy", 64'(bcnt), edz ? 64'd0 : 64'd9);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
